// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP program-RAM loader and its benches.
//   SAP_ADDR_W / SAP_DATA_W / SAP_DEPTH : RAM geometry (16 x 8)
//   HLT_OPCODE                          : HLT instruction opcode, used to
//                                         build program images
//   loader_state_e                      : loader FSM states
// Optional feature macro: LOADER_VERIFY_EN adds the two read-back states.
// ---------------------------------------------------------------------------
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;
  localparam int SAP_DEPTH  = 16;

  localparam logic [3:0] HLT_OPCODE = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ACCEPT     = 3'd1,
    ST_WRITE      = 3'd2,
`ifdef LOADER_VERIFY_EN
    ST_VERIFY_RD  = 3'd3,
    ST_VERIFY_CMP = 3'd4,
`endif
    ST_DONE       = 3'd5
  } loader_state_e;

endpackage

// File: rtl/ram_program_loader.sv
// ---------------------------------------------------------------------------
// ram_program_loader
// Writer side of the 16x8 program RAM. Accepts a byte stream over a
// valid/ready handshake, writes it to addresses 0..DEPTH-1 and holds the CPU
// until a full image has been written.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : one-cycle pulse, begins a load at address 0 (IDLE/DONE only)
//   in_data    : program byte from host
//   in_valid   : in_data valid
//   in_ready   : loader accepts a byte this cycle
//   ram_addr   : RAM address
//   ram_wdata  : RAM write data
//   ram_we     : RAM write strobe, one cycle per byte
//   ram_rdata  : registered RAM read data (read-back only)
//   busy       : load in progress
//   done       : full image written, held until next start
//   cpu_hold   : active-high CPU hold (CPU reset_n = ~cpu_hold)
//   load_count : bytes written in the current load, 0..DEPTH
//   err        : sticky read-back mismatch flag
//
// Optional feature macro: LOADER_VERIFY_EN
//   Defined  : every written byte is read back and compared (4 cycles/byte).
//   Undefined: 2 cycles/byte, ram_rdata ignored, err stays 0.
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module ram_program_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W,
  parameter int DEPTH  = SAP_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              ram_we_q, ram_we_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              err_q, err_d;
  logic              advance;

`ifndef LOADER_VERIFY_EN
  // Read data only matters for the read-back check.
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that each one is registered alongside the state it belongs to.
  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    load_count_d = load_count_q;
    ram_we_d     = ram_we_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    done_d       = done_q;
    cpu_hold_d   = cpu_hold_q;
    err_d        = err_q;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_ACCEPT;
          ram_addr_d   = '0;
          load_count_d = '0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          cpu_hold_d   = 1'b1;
          in_ready_d   = 1'b1;
        end
      end

      ST_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          state_d     = ST_WRITE;
          ram_wdata_d = in_data;
          ram_we_d    = 1'b1;
          in_ready_d  = 1'b0;
        end
      end

      ST_WRITE: begin
        ram_we_d     = 1'b0;
        load_count_d = load_count_q + (ADDR_W + 1)'(1);
`ifdef LOADER_VERIFY_EN
        state_d      = ST_VERIFY_RD;
`else
        advance      = 1'b1;
`endif
      end

`ifdef LOADER_VERIFY_EN
      // The RAM read was issued during WRITE; its registered data is valid
      // now, so the mismatch flag lands in VERIFY_CMP.
      ST_VERIFY_RD: begin
        state_d = ST_VERIFY_CMP;
        if (ram_rdata != ram_wdata_q) begin
          err_d = 1'b1;
        end
      end

      ST_VERIFY_CMP: begin
        advance = 1'b1;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Finish the current byte: either the image is complete or fetch the
    // next one. The address never wraps past the last word.
    if (advance) begin
      if (ram_addr_q == LAST_ADDR) begin
        state_d    = ST_DONE;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        cpu_hold_d = 1'b0;
        in_ready_d = 1'b0;
      end else begin
        state_d    = ST_ACCEPT;
        ram_addr_d = ram_addr_q + ADDR_W'(1);
        in_ready_d = 1'b1;
      end
    end
  end

  // State and output registers; the CPU stays held out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      load_count_q <= '0;
      ram_we_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      load_count_q <= load_count_d;
      ram_we_q     <= ram_we_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_hold_q   <= cpu_hold_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_count = load_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_program_loader
// Self-checking bench for ram_program_loader. Models the program RAM
// (write-first, registered read), logs every write strobe and checks the
// loader against hand-derived expectations.
// Optional feature macro: LOADER_VERIFY_EN selects the read-back scenario.
// ---------------------------------------------------------------------------
module tb_ram_program_loader;
  import sap_pkg::*;

`ifdef LOADER_VERIFY_EN
  localparam int CYC_PER_LOAD = 64;
`else
  localparam int CYC_PER_LOAD = 32;
`endif

  typedef struct {
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       exp_ready;
    logic       exp_we;
    logic [3:0] exp_addr;
    logic [7:0] exp_wdata;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_hold;
    logic [4:0] exp_count;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic       busy;
  logic       done;
  logic       cpu_hold;
  logic [4:0] load_count;
  logic       err;

  int checks = 0;
  int failures = 0;

  // RAM model and write log.
  logic [7:0] mem [16];
  logic [3:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  int         wr_count = 0;
  logic       log_clear = 1'b0;
  logic       corrupt3 = 1'b0;

  logic [7:0] img1 [16] = '{8'h09, 8'h1A, 8'h2B, 8'hE0, {HLT_OPCODE, 4'h0},
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] img2 [16];
  logic [7:0] img3 [16];
  logic [7:0] img4 [16];
  vec_t       vecs [33];

  ram_program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .load_count (load_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Program RAM: write-first registered read, optional corruption at word 3.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (corrupt3 && ram_addr == 4'd3) begin
      ram_rdata <= 8'hFF;
    end else begin
      ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end
    if (log_clear) begin
      wr_count <= 0;
    end else if (ram_we) begin
      if (wr_count < 64) begin
        wr_addr_log[wr_count] <= ram_addr;
        wr_data_log[wr_count] <= ram_wdata;
      end
      wr_count <= wr_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start    = v.start;
    in_valid = v.in_valid;
    in_data  = v.in_data;
    step();
    start = 1'b0;
  endtask

  task automatic verify_image(input string tag, input logic [7:0] img [16]);
    checkOutput($sformatf("%s.wr_count", tag), wr_count, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s.wr_addr[%0d]", tag, i), {28'd0, wr_addr_log[i]}, i);
      checkOutput($sformatf("%s.wr_data[%0d]", tag, i), {24'd0, wr_data_log[i]}, {24'd0, img[i]});
      checkOutput($sformatf("%s.mem[%0d]", tag, i), {24'd0, mem[i]}, {24'd0, img[i]});
    end
  endtask

  // Starts a load and acts as the host until done (or until abort_after
  // bytes are written). Sampling at posedge+1 makes in_ready stable, so the
  // handshake for the coming edge is known before it happens.
  task automatic run_load(input string tag, input logic [7:0] img [16],
                          input int gapped, input int glitch_addr, input int abort_after,
                          output int cycles, output int err_rise, output int consumed,
                          output int ready_viol);
    logic [3:0] pat;
    logic       glitched;
    logic       hs;
    logic       timed_out;
    pat        = 4'b1001;
    glitched   = 1'b0;
    timed_out  = 1'b1;
    cycles     = 0;
    err_rise   = -1;
    consumed   = 0;
    ready_viol = 0;
    start      = 1'b1;
    log_clear  = 1'b1;
    step();
    start     = 1'b0;
    log_clear = 1'b0;
    checkOutput({tag, ".start.cpu_hold"}, cpu_hold, 1);
    checkOutput({tag, ".start.addr"}, ram_addr, 0);
    checkOutput({tag, ".start.done"}, done, 0);
    checkOutput({tag, ".start.busy"}, busy, 1);
    checkOutput({tag, ".start.count"}, load_count, 0);
    checkOutput({tag, ".start.in_ready"}, in_ready, 1);
    checkOutput({tag, ".start.err"}, err, 0);
    for (int c = 0; c < 400; c++) begin
      in_valid = (gapped != 0) ? pat[c % 4] : 1'b1;
      in_data  = (consumed < 16) ? img[consumed] : 8'h00;
      start    = 1'b0;
      if (glitch_addr >= 0 && !glitched && in_ready && ram_addr == 4'(glitch_addr)) begin
        start    = 1'b1;
        glitched = 1'b1;
      end
      hs = in_valid && in_ready;
      step();
      cycles++;
      if (hs) consumed++;
      if (ram_we && in_ready) ready_viol++;
      if (err === 1'b1 && err_rise < 0) err_rise = int'(ram_addr);
      if (done === 1'b1 || (abort_after > 0 && wr_count == abort_after)) begin
        timed_out = 1'b0;
        break;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput({tag, ".timeout"}, timed_out, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, erise, cons, rviol;

    for (int i = 0; i < 16; i++) begin
      img2[i] = 8'(i * 17 + 3);
      img3[i] = 8'(8'hC5 ^ i);
      img4[i] = 8'(8'h80 + i * 3);
    end

    // Reset values after power-up.
    step();
    step();
    checkOutput("rst.ram_we", ram_we, 0);
    checkOutput("rst.in_ready", in_ready, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.cpu_hold", cpu_hold, 1);
    checkOutput("rst.load_count", load_count, 0);
    checkOutput("rst.ram_addr", ram_addr, 0);
    checkOutput("rst.ram_wdata", ram_wdata, 0);
    checkOutput("rst.err", err, 0);
    reset = 1'b1;
    step();

`ifndef LOADER_VERIFY_EN
    // Back-to-back load, cycle by cycle. Odd edges enter WRITE for byte
    // (j-1)/2, even edges return to ACCEPT; edge 32 reaches DONE.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0};
    for (int j = 1; j <= 32; j++) begin
      if (j % 2 == 1) begin
        vecs[j] = '{1'b0, 1'b1, img1[(j-1)/2], 1'b0, 1'b1, 4'((j-1)/2), img1[(j-1)/2],
                    1'b1, 1'b0, 1'b1, 5'((j-1)/2)};
      end else if (j < 32) begin
        vecs[j] = '{1'b0, 1'b1, img1[j/2], 1'b1, 1'b0, 4'(j/2), img1[j/2-1],
                    1'b1, 1'b0, 1'b1, 5'(j/2)};
      end else begin
        vecs[j] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd15, img1[15],
                    1'b0, 1'b1, 1'b0, 5'd16};
      end
    end
    log_clear = 1'b1;
    step();
    log_clear = 1'b0;
    for (int j = 0; j < 33; j++) begin
      applyStimulus(vecs[j]);
      checkOutput($sformatf("vec%0d.in_ready", j), in_ready, vecs[j].exp_ready);
      checkOutput($sformatf("vec%0d.ram_we", j), ram_we, vecs[j].exp_we);
      checkOutput($sformatf("vec%0d.ram_addr", j), ram_addr, vecs[j].exp_addr);
      checkOutput($sformatf("vec%0d.ram_wdata", j), ram_wdata, vecs[j].exp_wdata);
      checkOutput($sformatf("vec%0d.busy", j), busy, vecs[j].exp_busy);
      checkOutput($sformatf("vec%0d.done", j), done, vecs[j].exp_done);
      checkOutput($sformatf("vec%0d.cpu_hold", j), cpu_hold, vecs[j].exp_hold);
      checkOutput($sformatf("vec%0d.load_count", j), load_count, vecs[j].exp_count);
    end
    in_valid = 1'b0;
    step();
    step();
    checkOutput("b2b.done_held", done, 1);
    checkOutput("b2b.hold_released", cpu_hold, 0);
    checkOutput("b2b.err", err, 0);
    verify_image("b2b", img1);
`else
    // Read-back load with word 3 corrupted on the read path.
    corrupt3 = 1'b1;
    run_load("vfy", img1, 0, -1, 0, cyc, erise, cons, rviol);
    corrupt3 = 1'b0;
    checkOutput("vfy.cycles", cyc, CYC_PER_LOAD);
    checkOutput("vfy.err_rise_addr", erise, 3);
    checkOutput("vfy.ram_we_at_err", ram_we, 0);
    checkOutput("vfy.err_at_done", err, 1);
    checkOutput("vfy.done", done, 1);
    checkOutput("vfy.load_count", load_count, 16);
    verify_image("vfy", img1);
`endif

    // Gapped host stream restarting from DONE.
    run_load("gap", img2, 1, -1, 0, cyc, erise, cons, rviol);
    checkOutput("gap.consumed", cons, 16);
    checkOutput("gap.ready_in_write", rviol, 0);
    checkOutput("gap.err", erise, -1);
    checkOutput("gap.load_count", load_count, 16);
    verify_image("gap", img2);

    // start pulsed while byte 5 is pending must be ignored.
    run_load("glitch", img3, 0, 5, 0, cyc, erise, cons, rviol);
    checkOutput("glitch.cycles", cyc, CYC_PER_LOAD);
    checkOutput("glitch.cpu_hold", cpu_hold, 0);
    verify_image("glitch", img3);

    // Abort after byte 7 with an asynchronous reset.
    run_load("abort", img4, 0, -1, 8, cyc, erise, cons, rviol);
    checkOutput("abort.wr_count", wr_count, 8);
    checkOutput("abort.done_before", done, 0);
    reset = 1'b0;
    #1;
    checkOutput("arst.ram_we", ram_we, 0);
    checkOutput("arst.in_ready", in_ready, 0);
    checkOutput("arst.done", done, 0);
    checkOutput("arst.busy", busy, 0);
    checkOutput("arst.cpu_hold", cpu_hold, 1);
    checkOutput("arst.load_count", load_count, 0);
    checkOutput("arst.ram_addr", ram_addr, 0);
    step();
    reset = 1'b1;
    step();
    checkOutput("arst.idle_hold", cpu_hold, 1);
    run_load("reload", img4, 0, -1, 0, cyc, erise, cons, rviol);
    checkOutput("reload.cycles", cyc, CYC_PER_LOAD);
    checkOutput("reload.consumed", cons, 16);
    checkOutput("reload.err", erise, -1);
    checkOutput("reload.load_count", load_count, 16);
    verify_image("reload", img4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
